exe_stage: RTL and testbench

//  Execute stage of the 5-stage LoongArch pipeline, directly downstream of decode.

---
 rtl/exe_stage_if.sv | 41 ++++
 rtl/exe_stage.sv | 173 +++++++++++++++++
 tb/tb_exe_stage.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/exe_stage_if.sv
// exe_stage_if
//   Bundles the execute stage's pipeline handshake, the execute->memory bus,
//   the forwarding bundle back to decode and the data-SRAM request.
//   master : drives the decode-side inputs and the memory-stage back-pressure
//            (the surrounding pipeline or a testbench).
//   slave  : the execute stage itself.
//   Signals:
//     ds_to_es_valid / ds_to_es_bus  decode -> execute instruction
//     es_allowin                     execute can accept this cycle
//     ms_allowin                     memory stage can accept
//     es_to_ms_valid / es_to_ms_bus  execute -> memory result
//     es_rf_collect                  {not_ready,rf_we,waddr,result} to decode
//     data_sram_en/we/addr/wdata     data SRAM request
interface exe_stage_if #(
    parameter int DS_BUS_W = 155,
    parameter int ES_BUS_W = 71
);
    logic                ds_to_es_valid;
    logic                es_allowin;
    logic [DS_BUS_W-1:0] ds_to_es_bus;
    logic                ms_allowin;
    logic                es_to_ms_valid;
    logic [ES_BUS_W-1:0] es_to_ms_bus;
    logic [38:0]         es_rf_collect;
    logic                data_sram_en;
    logic [3:0]          data_sram_we;
    logic [31:0]         data_sram_addr;
    logic [31:0]         data_sram_wdata;

    modport master (
        output ds_to_es_valid, ds_to_es_bus, ms_allowin,
        input  es_allowin, es_to_ms_valid, es_to_ms_bus, es_rf_collect,
               data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata
    );

    modport slave (
        input  ds_to_es_valid, ds_to_es_bus, ms_allowin,
        output es_allowin, es_to_ms_valid, es_to_ms_bus, es_rf_collect,
               data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata
    );
endinterface

// File: rtl/exe_stage.sv
// exe_stage
//   Execute stage of the 5-stage LoongArch pipeline. Holds one instruction
//   from decode, computes the ALU / multiply / divide result, issues the
//   data-SRAM request and forwards the result to the memory stage.
//   Divides use a 32-iteration radix-2 restoring divider and stall the stage.
//   Ports:
//     clk    clock
//     reset  synchronous, active-high reset
//     es_if  exe_stage_if.slave (handshake, buses, forwarding, data SRAM)
//   Build option:
//     ES_DIV_ZERO_SHORTCUT_EN  when defined, a divide by zero skips the
//                              iterations and completes the cycle after entry.
module exe_stage #(
    parameter int DS_BUS_W  = 155,
    parameter int ES_BUS_W  = 71,
    parameter int DIV_ITERS = 32
) (
    input  logic       clk,
    input  logic       reset,
    exe_stage_if.slave es_if
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_e;

    localparam logic [4:0] CNT_LAST = 5'(DIV_ITERS - 1);

    logic                es_valid_q, es_valid_d;
    logic [DS_BUS_W-1:0] bus_q, bus_d;
    div_state_e          state_q, state_d;
    logic [4:0]          cnt_q, cnt_d;
    logic [31:0]         quo_q, quo_d;   // dividend shifts out, quotient shifts in
    logic [31:0]         rem_q, rem_d;
    logic [31:0]         dvs_q, dvs_d;

    logic [18:0] alu_op;
    logic        res_from_mem, mem_we, rf_we;
    logic [31:0] src1, src2, rkd, pc;
    logic [4:0]  waddr;

    assign {alu_op, res_from_mem, src1, src2, mem_we, rf_we, waddr, rkd, pc} = bus_q;

    logic is_div, div_signed, es_ready_go, es_allowin;
    assign is_div      = |alu_op[15:12];
    assign div_signed  = alu_op[15] | alu_op[14];
    assign es_ready_go = ~is_div | (state_q == DONE);
    assign es_allowin  = ~es_valid_q | (es_ready_go & es_if.ms_allowin);

    logic [31:0] abs1, abs2;
    assign abs1 = (div_signed & src1[31]) ? (~src1 + 32'd1) : src1;
    assign abs2 = (div_signed & src2[31]) ? (~src2 + 32'd1) : src2;

    // Partial remainder is always below the divisor, so trial - divisor fits 32 bits.
    logic [32:0] trial;
    logic        ge;
    assign trial = {rem_q, quo_q[31]};
    assign ge    = trial >= {1'b0, dvs_q};

    always_comb begin
        es_valid_d = es_allowin ? es_if.ds_to_es_valid : es_valid_q;
        bus_d      = (es_if.ds_to_es_valid & es_allowin) ? es_if.ds_to_es_bus : bus_q;
        state_d    = state_q;
        cnt_d      = cnt_q;
        quo_d      = quo_q;
        rem_d      = rem_q;
        dvs_d      = dvs_q;
        case (state_q)
            IDLE: begin
                if (es_valid_q & is_div) begin
                    quo_d = abs1;
                    dvs_d = abs2;
                    rem_d = '0;
                    cnt_d = '0;
`ifdef ES_DIV_ZERO_SHORTCUT_EN
                    state_d = (src2 == '0) ? DONE : RUN;
`else
                    state_d = RUN;
`endif
                end
            end
            RUN: begin
                rem_d = ge ? 32'(trial - {1'b0, dvs_q}) : trial[31:0];
                quo_d = {quo_q[30:0], ge};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == CNT_LAST) state_d = DONE;
            end
            DONE: begin
                if (es_if.ms_allowin) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            es_valid_q <= 1'b0;
            bus_q      <= '0;
            state_q    <= IDLE;
            cnt_q      <= '0;
            quo_q      <= '0;
            rem_q      <= '0;
            dvs_q      <= '0;
        end else begin
            es_valid_q <= es_valid_d;
            bus_q      <= bus_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            quo_q      <= quo_d;
            rem_q      <= rem_d;
            dvs_q      <= dvs_d;
        end
    end

    // alu_op[11:0]: add sub slt sltu and nor or xor sll srl sra lui
    logic [31:0] alu_result;
    always_comb begin
        alu_result = '0;
        if (alu_op[0])  alu_result = src1 + src2;
        if (alu_op[1])  alu_result = src1 - src2;
        if (alu_op[2])  alu_result = {31'd0, $signed(src1) < $signed(src2)};
        if (alu_op[3])  alu_result = {31'd0, src1 < src2};
        if (alu_op[4])  alu_result = src1 & src2;
        if (alu_op[5])  alu_result = ~(src1 | src2);
        if (alu_op[6])  alu_result = src1 | src2;
        if (alu_op[7])  alu_result = src1 ^ src2;
        if (alu_op[8])  alu_result = src1 << src2[4:0];
        if (alu_op[9])  alu_result = src1 >> src2[4:0];
        if (alu_op[10]) alu_result = 32'($signed(src1) >>> src2[4:0]);
        if (alu_op[11]) alu_result = src2;
    end

    // One 64-bit multiply serves all three: operands are sign- or zero-extended
    // and the low 64 product bits are then exact for either interpretation.
    logic        mul_signed;
    logic [63:0] mul_a, mul_b, prod;
    assign mul_signed = alu_op[18] | alu_op[17];
    assign mul_a      = {{32{mul_signed & src1[31]}}, src1};
    assign mul_b      = {{32{mul_signed & src2[31]}}, src2};
    assign prod       = mul_a * mul_b;

    logic [31:0] q_out, r_out;
    always_comb begin
        q_out = quo_q;
        r_out = rem_q;
        if (src2 == '0) begin
            q_out = '1;
            r_out = src1;
        end else if (div_signed) begin
            if (src1[31] ^ src2[31]) q_out = ~quo_q + 32'd1;
            if (src1[31])            r_out = ~rem_q + 32'd1;
        end
    end

    logic [31:0] result;
    always_comb begin
        result = alu_result;
        if (alu_op[18])                    result = prod[31:0];
        else if (alu_op[17] | alu_op[16])  result = prod[63:32];
        else if (alu_op[15] | alu_op[13])  result = q_out;
        else if (alu_op[14] | alu_op[12])  result = r_out;
    end

    logic [ES_BUS_W-1:0] es_bus;
    assign es_bus = {res_from_mem, rf_we, waddr, result, pc};

    assign es_if.es_allowin      = es_allowin;
    assign es_if.es_to_ms_valid  = es_valid_q & es_ready_go;
    assign es_if.es_to_ms_bus    = es_bus;
    assign es_if.es_rf_collect   = {es_valid_q & (res_from_mem | (is_div & (state_q != DONE))),
                                    es_valid_q & rf_we, waddr, result};
    assign es_if.data_sram_en    = es_valid_q & (res_from_mem | mem_we);
    assign es_if.data_sram_we    = {4{es_valid_q & mem_we}};
    assign es_if.data_sram_addr  = alu_result;
    assign es_if.data_sram_wdata = rkd;
endmodule

// File: tb/tb_exe_stage.sv
module tb_exe_stage;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    exe_stage_if bif ();

    exe_stage #(.DS_BUS_W(155), .ES_BUS_W(71), .DIV_ITERS(32)) dut (
        .clk   (clk),
        .reset (reset),
        .es_if (bif)
    );

    localparam int OP_ADD = 0, OP_SUB = 1, OP_SLT = 2, OP_SLTU = 3, OP_AND = 4, OP_NOR = 5,
                   OP_OR = 6, OP_XOR = 7, OP_SLL = 8, OP_SRL = 9, OP_SRA = 10, OP_LUI = 11,
                   OP_MOD_WU = 12, OP_DIV_WU = 13, OP_MOD_W = 14, OP_DIV_W = 15,
                   OP_MULH_WU = 16, OP_MULH_W = 17, OP_MUL_W = 18;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [70:0] obs, input logic [70:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference arithmetic straight from the instruction semantics.
    function automatic logic [31:0] ref_res(input int op, input logic [31:0] a, input logic [31:0] b);
        longint      sp;
        logic [63:0] sv;
        logic [63:0] up;
        int          sa, sb;
        sa = a;
        sb = b;
        sp = longint'(sa) * longint'(sb);
        sv = sp;
        up = {32'd0, a} * {32'd0, b};
        case (op)
            OP_ADD:     return a + b;
            OP_SUB:     return a - b;
            OP_SLT:     return (sa < sb) ? 32'd1 : 32'd0;
            OP_SLTU:    return (a < b) ? 32'd1 : 32'd0;
            OP_AND:     return a & b;
            OP_NOR:     return ~(a | b);
            OP_OR:      return a | b;
            OP_XOR:     return a ^ b;
            OP_SLL:     return a << b[4:0];
            OP_SRL:     return a >> b[4:0];
            OP_SRA:     return 32'(sa >>> b[4:0]);
            OP_LUI:     return b;
            OP_MUL_W:   return sv[31:0];
            OP_MULH_W:  return sv[63:32];
            OP_MULH_WU: return up[63:32];
            OP_DIV_WU:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
            OP_MOD_WU:  return (b == 0) ? a : a % b;
            OP_DIV_W: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(sa / sb);
            end
            OP_MOD_W: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(sa % sb);
            end
            default:    return 32'd0;
        endcase
    endfunction

    function automatic int ref_lat(input int op, input logic [31:0] b);
        if (op < OP_MOD_WU || op > OP_DIV_W) return 0;
`ifdef ES_DIV_ZERO_SHORTCUT_EN
        if (b == 0) return 1;
`endif
        return 33;
    endfunction

    function automatic logic [154:0] mk(input int op, input logic rfm, input logic [31:0] a,
                                        input logic [31:0] b, input logic mwe, input logic rwe,
                                        input logic [4:0] wa, input logic [31:0] rkd,
                                        input logic [31:0] pc);
        logic [18:0] aop;
        aop = 19'd1 << op;
        return {aop, rfm, a, b, mwe, rwe, wa, rkd, pc};
    endfunction

    // Presents one instruction; returns just after the capturing edge (cycle 0).
    task automatic issue(input logic [154:0] b);
        @(negedge clk);
        bif.ds_to_es_valid = 1'b1;
        bif.ds_to_es_bus   = b;
        check("allowin_at_issue", bif.es_allowin, 1'b1);
        @(posedge clk);
        #1;
        bif.ds_to_es_valid = 1'b0;
    endtask

    // Caller sits at the negedge of cycle 'start'; returns at the valid cycle.
    task automatic wait_valid(input int start, output int lat);
        lat = start;
        while (bif.es_to_ms_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_tx(input int op, input logic rfm, input logic [31:0] a, input logic [31:0] b,
                          input logic mwe, input logic rwe, input logic [4:0] wa,
                          input logic [31:0] rkd, input logic [31:0] pc, output logic [31:0] got);
        int          lat;
        logic [31:0] exp;
        exp = ref_res(op, a, b);
        issue(mk(op, rfm, a, b, mwe, rwe, wa, rkd, pc));
        @(negedge clk);
        wait_valid(0, lat);
        check("latency", 71'(lat), 71'(ref_lat(op, b)));
        check("es_to_ms_bus", bif.es_to_ms_bus, {rfm, rwe, wa, exp, pc});
        check("rf_collect", 71'(bif.es_rf_collect), 71'({rfm, rwe, wa, exp}));
        check("sram_en", bif.data_sram_en, rfm | mwe);
        check("sram_we", bif.data_sram_we, {4{mwe}});
        check("sram_wdata", bif.data_sram_wdata, rkd);
        if (op <= OP_LUI) check("sram_addr", bif.data_sram_addr, exp);
        got = bif.es_to_ms_bus[63:32];
    endtask

    initial begin
        logic [31:0] got, a, b, rkd, pc, held;
        logic        rfm, mwe, rwe;
        logic [4:0]  wa;
        int          lat, op, sel;

        // Reset state
        reset = 1'b1;
        bif.ds_to_es_valid = 1'b0;
        bif.ds_to_es_bus   = '0;
        bif.ms_allowin     = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", bif.es_to_ms_valid, 1'b0);
        check("rst_allowin", bif.es_allowin, 1'b1);
        check("rst_bus", bif.es_to_ms_bus, 71'd0);
        check("rst_collect", 71'(bif.es_rf_collect), 71'd0);
        check("rst_sram", {bif.data_sram_en, bif.data_sram_we, bif.data_sram_addr, bif.data_sram_wdata},
              71'd0);
        reset = 1'b0;

        // 1: add
        run_tx(OP_ADD, 0, 32'd5, 32'd7, 0, 1, 5'd3, 32'd0, 32'h1c00_0000, got);
        check("add_result", got, 32'd12);

        // 2: multiplies
        run_tx(OP_MUL_W, 0, 32'hFFFF_FFFF, 32'd2, 0, 1, 5'd4, 32'd0, 32'h1c00_0004, got);
        check("mul_w", got, 32'hFFFF_FFFE);
        run_tx(OP_MULH_W, 0, 32'hFFFF_FFFF, 32'd2, 0, 1, 5'd4, 32'd0, 32'h1c00_0008, got);
        check("mulh_w", got, 32'hFFFF_FFFF);
        run_tx(OP_MULH_WU, 0, 32'hFFFF_FFFF, 32'd2, 0, 1, 5'd4, 32'd0, 32'h1c00_000c, got);
        check("mulh_wu", got, 32'h0000_0001);

        // 3: signed divide, stall visible mid-way
        issue(mk(OP_DIV_W, 0, 32'hFFFF_FFF9, 32'd2, 0, 1, 5'd6, 32'd0, 32'h1c00_0010));
        @(negedge clk);
        repeat (10) @(negedge clk);
        check("div_stall_allowin", bif.es_allowin, 1'b0);
        check("div_stall_notready", bif.es_rf_collect[38], 1'b1);
        check("div_stall_valid", bif.es_to_ms_valid, 1'b0);
        wait_valid(10, lat);
        check("div_w_latency", 71'(lat), 71'd33);
        check("div_w_q", bif.es_to_ms_bus[63:32], 32'hFFFF_FFFD);
        run_tx(OP_MOD_W, 0, 32'hFFFF_FFF9, 32'd2, 0, 1, 5'd6, 32'd0, 32'h1c00_0014, got);
        check("mod_w_r", got, 32'hFFFF_FFFF);

        // 4: back-pressure in DONE
        issue(mk(OP_DIV_WU, 0, 32'd100, 32'd7, 0, 1, 5'd7, 32'd0, 32'h1c00_0018));
        @(negedge clk);
        repeat (32) @(negedge clk);
        bif.ms_allowin = 1'b0;
        @(negedge clk);
        check("bp_first_valid", bif.es_to_ms_valid, 1'b1);
        held = bif.es_to_ms_bus[63:32];
        check("bp_result", held, 32'd14);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_valid", bif.es_to_ms_valid, 1'b1);
            check("bp_hold_bus", bif.es_to_ms_bus, {1'b0, 1'b1, 5'd7, 32'd14, 32'h1c00_0018});
            check("bp_hold_allowin", bif.es_allowin, 1'b0);
            check("bp_hold_notready", bif.es_rf_collect[38], 1'b0);
        end
        bif.ms_allowin = 1'b1;
        @(negedge clk);
        check("bp_release_valid", bif.es_to_ms_valid, 1'b0);
        run_tx(OP_DIV_WU, 0, 32'd100, 32'd9, 0, 1, 5'd7, 32'd0, 32'h1c00_001c, got);
        check("bp_next_div", got, 32'd11);

        // 5: divide by zero
        run_tx(OP_DIV_WU, 0, 32'd9, 32'd0, 0, 1, 5'd8, 32'd0, 32'h1c00_0020, got);
        check("divz_q", got, 32'hFFFF_FFFF);
        run_tx(OP_MOD_WU, 0, 32'd9, 32'd0, 0, 1, 5'd8, 32'd0, 32'h1c00_0024, got);
        check("divz_r", got, 32'd9);
        run_tx(OP_DIV_W, 0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1, 5'd9, 32'd0, 32'h1c00_0028, got);
        check("div_ovf_q", got, 32'h8000_0000);

        // 6: reset during RUN (cnt==10), then a store
        issue(mk(OP_DIV_W, 0, 32'd1000, 32'd3, 0, 1, 5'd10, 32'd0, 32'h1c00_002c));
        @(negedge clk);
        repeat (11) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_valid", bif.es_to_ms_valid, 1'b0);
        check("abort_allowin", bif.es_allowin, 1'b1);
        check("abort_collect", 71'(bif.es_rf_collect), 71'd0);
        run_tx(OP_ADD, 0, 32'h100, 32'd4, 1, 0, 5'd0, 32'hAB, 32'h1c00_0030, got);
        check("store_addr", got, 32'h104);
        run_tx(OP_DIV_W, 0, 32'd1000, 32'd3, 0, 1, 5'd10, 32'd0, 32'h1c00_0034, got);
        check("post_abort_div", got, 32'd333);

        // Randomised mix against the reference model
        for (int n = 0; n < 40; n++) begin
            op  = int'($urandom_range(0, 18));
            a   = $urandom;
            b   = $urandom;
            sel = int'($urandom_range(0, 7));
            if (sel == 0) b = 32'd0;
            else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (sel == 2) b = 32'($urandom_range(1, 40));
            rfm = 1'b0;
            mwe = 1'b0;
            if (op <= OP_LUI) begin
                sel = int'($urandom_range(0, 2));
                rfm = (sel == 1);
                mwe = (sel == 2);
            end
            rwe = 1'($urandom_range(0, 1));
            wa  = 5'($urandom_range(0, 31));
            rkd = $urandom;
            pc  = $urandom;
            run_tx(op, rfm, a, b, mwe, rwe, wa, rkd, pc, got);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
